// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: IF/ID-to-ID/EX control bundle between the fetch side and the control unit
interface pipelined_control_unit_if #(
   parameter int REG_ADDR_W = 4,
   parameter int ALUOP_W    = 3
);
   logic                  instr_valid;
   logic [1:0]            instruction_type;
   logic [4:0]            func;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   logic                  stall_in, flush_in;
   logic                  ex_valid;
   logic                  JumpI, JumpCI, JumpCD, MemToReg, MemRead, MemWrite, ALUSrc, RegWrite, RegSrc2;
   logic [ALUOP_W-1:0]    ALUOp;
   logic [1:0]            ImmSrc, RegDtn, RegSrc1;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  illegal, stall_out, shadow_busy;
   modport master (
      output instr_valid, instruction_type, func, rs1, rs2, rd, stall_in, flush_in,
      input  ex_valid, JumpI, JumpCI, JumpCD, MemToReg, MemRead, MemWrite, ALUSrc, RegWrite, RegSrc2,
      input  ALUOp, ImmSrc, RegDtn, RegSrc1, ex_rd, illegal, stall_out, shadow_busy
   );
   modport slave (
      input  instr_valid, instruction_type, func, rs1, rs2, rd, stall_in, flush_in,
      output ex_valid, JumpI, JumpCI, JumpCD, MemToReg, MemRead, MemWrite, ALUSrc, RegWrite, RegSrc2,
      output ALUOp, ImmSrc, RegDtn, RegSrc1, ex_rd, illegal, stall_out, shadow_busy
   );
endinterface

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: registered decoder with load-use bubble, jump-shadow squash, stall and flush
module pipelined_control_unit #(
   parameter int REG_ADDR_W    = 4,
   parameter int ALUOP_W       = 3,
   parameter int BRANCH_SHADOW = 2
) (
   input logic                     clk,
   input logic                     rst,
   pipelined_control_unit_if.slave bus
);
   localparam int CW = (BRANCH_SHADOW < 1) ? 1 : $clog2(BRANCH_SHADOW + 1);
   typedef struct packed {
      logic                  ex_valid;
      logic                  jump_i, jump_ci, jump_cd, mem_to_reg, mem_read, mem_write, alu_src, reg_write, reg_src2;
      logic [ALUOP_W-1:0]    alu_op;
      logic [1:0]            imm_src, reg_dtn, reg_src1;
      logic [REG_ADDR_W-1:0] ex_rd;
   } ctl_t;
   ctl_t          w_dec, r_ctl;
   logic [2:0]    w_use;
   logic          w_legal, w_busy, w_hazard, w_squash, w_jump, r_illegal;
   logic [CW-1:0] r_cnt;
   // decode the IF/ID instruction; w_use marks which of {rd, rs2, rs1} it reads
   always_comb begin
      w_dec   = '0;
      w_legal = 1'b0;
      w_use   = 3'b000;
      case (bus.instruction_type)
         2'b10: if (!bus.func[4]) begin
            w_legal          = !bus.func[3] && bus.func[2:0] <= 3'd4;
            w_dec.alu_op     = ALUOP_W'(bus.func[2:0]);
            w_dec.reg_write  = 1'b1;
            w_dec.reg_dtn    = 2'b01;
            w_dec.reg_src2   = 1'b1;
            w_dec.reg_src1   = 2'b10;
            w_use            = 3'b011;
         end else begin
            w_legal          = bus.func[3] && bus.func[2:0] <= 3'd5;
            w_dec.alu_op     = ALUOP_W'(bus.func[2:0]);
            w_dec.alu_src    = 1'b1;
            w_dec.imm_src    = 2'b10;
            w_dec.reg_write  = 1'b1;
            w_dec.reg_dtn    = 2'b01;
            w_dec.reg_src1   = 2'b10;
            w_use            = 3'b001;
         end
         2'b00: begin
            w_legal          = bus.func[4:3] != 2'b01;
            w_dec.jump_i     = bus.func[4:3] == 2'b00;
            w_dec.jump_ci    = bus.func[4:3] == 2'b10;
            w_dec.jump_cd    = bus.func[4:3] == 2'b11;
            w_dec.alu_op     = ALUOP_W'(1);
         end
         2'b01: begin
            w_legal          = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.imm_src    = 2'b01;
            w_dec.reg_src1   = 2'b01;
            w_dec.mem_write  = !bus.func[4];
            w_dec.mem_to_reg = bus.func[4];
            w_dec.mem_read   = bus.func[4];
            w_dec.reg_write  = bus.func[4];
            w_use            = bus.func[4] ? 3'b001 : 3'b101;
         end
         default: w_legal = 1'b0;
      endcase
      w_dec.ex_valid = 1'b1;
      w_dec.ex_rd    = bus.rd;
      if (!(bus.instr_valid && w_legal)) begin
         w_dec = '0;
         w_use = 3'b000;
      end
   end
   assign w_busy   = r_cnt != '0;
   assign w_jump   = w_dec.jump_i | w_dec.jump_ci | w_dec.jump_cd;
   assign w_hazard = !w_busy && r_ctl.ex_valid && r_ctl.mem_read &&
                     ((w_use[0] && bus.rs1 == r_ctl.ex_rd) ||
                      (w_use[1] && bus.rs2 == r_ctl.ex_rd) ||
                      (w_use[2] && bus.rd  == r_ctl.ex_rd));
   assign w_squash = w_hazard || (w_busy && bus.instr_valid);
   // ID/EX register and shadow counter; flush beats stall, stall beats everything else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctl     <= '0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else if (bus.flush_in) begin
         r_ctl     <= '0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else if (!bus.stall_in) begin
         r_ctl     <= w_squash ? '0 : w_dec;
         r_illegal <= !w_squash && bus.instr_valid && !w_legal;
         r_cnt     <= w_busy ? r_cnt - 1'b1 : (w_jump && !w_squash) ? CW'(BRANCH_SHADOW) : '0;
      end
   end
   assign bus.ex_valid    = r_ctl.ex_valid;
   assign bus.JumpI       = r_ctl.jump_i;
   assign bus.JumpCI      = r_ctl.jump_ci;
   assign bus.JumpCD      = r_ctl.jump_cd;
   assign bus.MemToReg    = r_ctl.mem_to_reg;
   assign bus.MemRead     = r_ctl.mem_read;
   assign bus.MemWrite    = r_ctl.mem_write;
   assign bus.ALUSrc      = r_ctl.alu_src;
   assign bus.RegWrite    = r_ctl.reg_write;
   assign bus.RegSrc2     = r_ctl.reg_src2;
   assign bus.ALUOp       = r_ctl.alu_op;
   assign bus.ImmSrc      = r_ctl.imm_src;
   assign bus.RegDtn      = r_ctl.reg_dtn;
   assign bus.RegSrc1     = r_ctl.reg_src1;
   assign bus.ex_rd       = r_ctl.ex_rd;
   assign bus.illegal     = r_illegal;
   assign bus.shadow_busy = w_busy;
   assign bus.stall_out   = !rst && (bus.stall_in || w_hazard);
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: scoreboard bench against a rule-level reference model
module tb_pipelined_control_unit;
   localparam int SHADOW = 2;
   typedef struct {
      logic [24:0] v;
      logic        so;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_chk = 0;
   int          n_pass = 0;
   exp_t        q[$];
   logic        m_v = 1'b0, m_ill = 1'b0;
   logic [17:0] m_c = '0;
   logic [3:0]  m_rd = '0;
   int          m_cnt = 0;
   logic        last_so = 1'b0;
   logic        mon_so;
   exp_t        mon_e;
   pipelined_control_unit_if #(.REG_ADDR_W(4), .ALUOP_W(3)) bus ();
   pipelined_control_unit #(.REG_ADDR_W(4), .ALUOP_W(3), .BRANCH_SHADOW(SHADOW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   function automatic logic [24:0] actual();
      return {bus.ex_valid, bus.JumpI, bus.JumpCI, bus.JumpCD, bus.MemToReg, bus.MemRead, bus.MemWrite,
              bus.ALUSrc, bus.RegWrite, bus.RegSrc2, bus.ALUOp, bus.ImmSrc, bus.RegDtn, bus.RegSrc1,
              bus.ex_rd, bus.illegal, bus.shadow_busy};
   endfunction
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
   endtask
   // instruction table: controls {JumpI,JumpCI,JumpCD,MemToReg,MemRead,MemWrite,ALUSrc,RegWrite,RegSrc2,
   // ALUOp,ImmSrc,RegDtn,RegSrc1}, sources {rd,rs2,rs1}
   function automatic void ref_decode(input logic [1:0] ty, input logic [4:0] fn,
                                      output logic ok, output logic [17:0] c, output logic [2:0] src);
      logic [2:0] op;
      op  = fn[2:0];
      ok  = 1'b0;
      c   = '0;
      src = '0;
      if (ty == 2'd2 && fn[4:3] == 2'b00 && op <= 3'd4) begin
         ok = 1'b1; c = {9'b000000011, op, 2'b00, 2'b01, 2'b10}; src = 3'b011;
      end else if (ty == 2'd2 && fn[4:3] == 2'b11 && op <= 3'd5) begin
         ok = 1'b1; c = {9'b000000110, op, 2'b10, 2'b01, 2'b10}; src = 3'b001;
      end else if (ty == 2'd0 && fn[4:3] != 2'b01) begin
         ok = 1'b1;
         c = {fn[4:3] == 2'b00, fn[4:3] == 2'b10, fn[4:3] == 2'b11, 6'b000000, 3'b001, 6'b000000};
      end else if (ty == 2'd1 && !fn[4]) begin
         ok = 1'b1; c = {9'b000001100, 3'b000, 2'b01, 2'b00, 2'b01}; src = 3'b101;
      end else if (ty == 2'd1) begin
         ok = 1'b1; c = {9'b000110110, 3'b000, 2'b01, 2'b00, 2'b01}; src = 3'b001;
      end
   endfunction
   task automatic cyc(input logic iv, input logic [1:0] ty, input logic [4:0] fn,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                      input logic st, input logic fl);
      logic ok, okv, busy, hz;
      logic [17:0] c;
      logic [2:0] src;
      exp_t e;
      @(negedge clk);
      bus.instr_valid = iv; bus.instruction_type = ty; bus.func = fn;
      bus.rs1 = s1; bus.rs2 = s2; bus.rd = d; bus.stall_in = st; bus.flush_in = fl;
      ref_decode(ty, fn, ok, c, src);
      okv  = ok && iv;
      busy = m_cnt != 0;
      hz   = okv && !busy && m_v && m_c[13] &&
             ((src[0] && s1 == m_rd) || (src[1] && s2 == m_rd) || (src[2] && d == m_rd));
      e.so = st || hz;
      if (fl) begin
         m_v = 0; m_c = '0; m_rd = '0; m_ill = 0; m_cnt = 0;
      end else if (!st) begin
         if (hz || (busy && iv)) begin
            m_v = 0; m_c = '0; m_rd = '0; m_ill = 0;
            if (busy) m_cnt--;
         end else begin
            m_v   = okv;
            m_c   = okv ? c : '0;
            m_rd  = okv ? d : '0;
            m_ill = iv && !ok;
            if (okv && (c[17] || c[16] || c[15])) m_cnt = SHADOW;
            else if (m_cnt > 0) m_cnt--;
         end
      end
      e.v = {m_v, m_c, m_rd, m_ill, m_cnt != 0};
      last_so = e.so;
      q.push_back(e);
   endtask
   // monitor: sample the combinational hold request mid-cycle and the registers just after the edge
   initial forever begin
      @(negedge clk);
      #3;
      if (q.size() == 0) continue;
      mon_so = bus.stall_out;
      @(posedge clk);
      #1;
      mon_e = q.pop_front();
      chk("stall_out", {31'b0, mon_so}, {31'b0, mon_e.so});
      chk("id_ex", {7'b0, actual()}, {7'b0, mon_e.v});
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
   initial begin
      logic iv, st, fl;
      logic [1:0] ty;
      logic [4:0] fn;
      logic [3:0] s1, s2, d;
      iv = 0; ty = 0; fn = 0; s1 = 0; s2 = 0; d = 0;
      bus.instr_valid = 0; bus.instruction_type = 0; bus.func = 0;
      bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.stall_in = 1; bus.flush_in = 0;
      #1;
      chk("reset_regs", {7'b0, actual()}, 32'd0);
      chk("reset_stall_out", {31'b0, bus.stall_out}, 32'd0);
      bus.stall_in = 0;
      @(negedge clk);
      rst = 0;
      cyc(1, 2'd2, 5'b00000, 4'd1, 4'd2, 4'd3, 0, 0);
      cyc(1, 2'd1, 5'b10000, 4'd0, 4'd0, 4'd5, 0, 0);
      cyc(1, 2'd2, 5'b11000, 4'd5, 4'd0, 4'd7, 0, 0);
      cyc(1, 2'd2, 5'b11000, 4'd5, 4'd0, 4'd7, 0, 0);
      cyc(1, 2'd0, 5'b00000, 4'd0, 4'd0, 4'd0, 0, 0);
      repeat (3) cyc(1, 2'd2, 5'b00001, 4'd1, 4'd2, 4'd3, 0, 0);
      cyc(1, 2'd3, 5'b00000, 4'd1, 4'd2, 4'd3, 0, 0);
      cyc(1, 2'd2, 5'b10101, 4'd1, 4'd2, 4'd3, 0, 0);
      cyc(1, 2'd0, 5'b01000, 4'd1, 4'd2, 4'd3, 0, 0);
      cyc(1, 2'd2, 5'b00100, 4'd1, 4'd2, 4'd3, 0, 0);
      cyc(1, 2'd0, 5'b10000, 4'd0, 4'd0, 4'd0, 0, 0);
      repeat (3) cyc(1, 2'd2, 5'b00010, 4'd1, 4'd2, 4'd3, 1, 0);
      cyc(1, 2'd2, 5'b00010, 4'd1, 4'd2, 4'd3, 1, 1);
      cyc(1, 2'd2, 5'b00011, 4'd1, 4'd2, 4'd3, 0, 0);
      cyc(1, 2'd0, 5'b11000, 4'd0, 4'd0, 4'd0, 0, 0);
      cyc(0, 2'd2, 5'b00000, 4'd0, 4'd0, 4'd0, 0, 0);
      cyc(0, 2'd2, 5'b00000, 4'd0, 4'd0, 4'd0, 0, 0);
      cyc(1, 2'd1, 5'b00000, 4'd2, 4'd0, 4'd9, 0, 0);
      for (int i = 0; i < 600; i++) begin
         if (!last_so) begin
            iv = ($urandom % 8) != 0;
            ty = 2'($urandom % 4);
            if (ty == 2'd3 && ($urandom % 2) == 0) ty = 2'd1;
            fn = 5'($urandom);
            if (ty == 2'd2 && ($urandom % 8) != 0)
               fn = ($urandom % 2) ? {2'b11, 3'($urandom_range(5, 0))} : {2'b00, 3'($urandom_range(4, 0))};
            s1 = 4'($urandom % 4);
            s2 = 4'($urandom % 4);
            d  = 4'($urandom % 4);
         end
         st = ($urandom % 10) == 0;
         fl = ($urandom % 25) == 0;
         cyc(iv, ty, fn, s1, s2, d, st, fl);
      end
      cyc(0, 2'd0, 5'b00000, 4'd0, 4'd0, 4'd0, 0, 1);
      cyc(1, 2'd1, 5'b10000, 4'd0, 4'd0, 4'd5, 0, 0);
      @(negedge clk);
      bus.instr_valid = 1; bus.instruction_type = 2'd2; bus.func = 5'b11000;
      bus.rs1 = 4'd5; bus.rs2 = 4'd0; bus.rd = 4'd7; bus.stall_in = 0; bus.flush_in = 0;
      #2;
      chk("hazard_stall_out", {31'b0, bus.stall_out}, 32'd1);
      rst = 1;
      #1;
      chk("async_reset_regs", {7'b0, actual()}, 32'd0);
      chk("async_reset_stall_out", {31'b0, bus.stall_out}, 32'd0);
      m_v = 0; m_c = '0; m_rd = '0; m_ill = 0; m_cnt = 0;
      @(negedge clk);
      rst = 0;
      cyc(1, 2'd2, 5'b11101, 4'd5, 4'd0, 4'd7, 0, 0);
      cyc(0, 2'd0, 5'b00000, 4'd0, 4'd0, 4'd0, 0, 0);
      for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
      #2;
      chk("drain", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered successor to the combinational decoder: decodes `instruction_type`/`func` into the control bundle and writes it into the ID/EX control register.
- Adds load-use hazard detection with a one-cycle bubble, a parametrised jump-shadow squash counter, external stall and flush, and an illegal-opcode flag.
- Sits between the IF/ID register and the EX stage of the pipeline processor.

Parameters:
- `REG_ADDR_W`, 4, width of the register specifiers `rs1`, `rs2`, `rd`.
- `ALUOP_W`, 3, width of `ALUOp`; must be ≥ 3.
- `BRANCH_SHADOW`, 2, number of valid slots squashed after a jump issues; 0 disables squashing.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `instr_valid`  in  1  IF/ID holds a real instruction.
- `instruction_type`  in  2  opcode class.
- `func`  in  5  function field.
- `rs1`, `rs2`, `rd`  in  `REG_ADDR_W` each  register specifiers from IF/ID.
- `stall_in`  in  1  downstream hold.
- `flush_in`  in  1  kill from branch resolution.
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `JumpI`, `JumpCI`, `JumpCD`, `MemToReg`, `MemRead`, `MemWrite`, `ALUSrc`, `RegWrite`, `RegSrc2`  out  1 each  registered controls.
- `ALUOp`  out  `ALUOP_W`  registered control.
- `ImmSrc`, `RegDtn`, `RegSrc1`  out  2 each  registered controls.
- `ex_rd`  out  `REG_ADDR_W`  registered destination.
- `illegal`  out  1  registered one-cycle illegal flag.
- `stall_out`  out  1  combinational hold request to PC and IF/ID.
- `shadow_busy`  out  1  shadow counter nonzero.

Behaviour:
- Reset (async, `rst`=1): every registered output is 0 and the shadow counter is 0. `stall_out`=0 while `rst`=1.
- Decode (combinational), then registered: latency 1 cycle. Don't-care fields are driven 0.
- Type 10, `func[4]`=0:
  - `func` 00000..00100 → `ALUOp` 0..4.
  - `RegWrite`=1, `RegDtn`=01, `RegSrc2`=1, `RegSrc1`=10, `ALUSrc`=0.
  - Sources: `rs1`, `rs2`.
- Type 10, `func[4]`=1:
  - `func` 11000..11101 → `ALUOp` 0..5.
  - `ALUSrc`=1, `ImmSrc`=10, `RegWrite`=1, `RegDtn`=01, `RegSrc1`=10.
  - Source: `rs1`.
- Type 00 (jump):
  - `func[4:3]` 00 → `JumpI`; 10 → `JumpCI`; 11 → `JumpCD`.
  - `ALUOp`=001, `ImmSrc`=00, `RegSrc1`=00.
  - No sources.
- Type 01 (memory):
  - `ALUSrc`=1, `ImmSrc`=01, `RegSrc1`=01.
  - GDR (`func[4]`=0): `MemWrite`=1; sources `rs1`, `rd`.
  - CRG (`func[4]`=1): `MemToReg`=1, `MemRead`=1, `RegWrite`=1, `RegDtn`=00; source `rs1`.
- Illegal: type 11, unlisted `func` codes, or type 00 with `func[4:3]`=01. Writes a bubble; `illegal`=1 for one cycle.
- Bubble: all controls 0, `ex_valid`=0, `ex_rd`=0.
- Hazard: `hazard` = `instr_valid` & !`shadow_busy` & `ex_valid` & `MemRead` & (`ex_rd` equals any source of the current instruction).
- Per-edge priority:
  1. `flush_in`: bubble; counter←0; `illegal`←0.
  2. `stall_in`: all registers and counter hold.
  3. `hazard`: bubble, counter holds. `stall_out`=1 this cycle; the same instruction re-decodes next cycle.
  4. `shadow_busy` & `instr_valid`: bubble; counter decrements.
  5. Else: write the decoded bundle; `ex_valid`=`instr_valid`.
- Counter rules:
  - Counter ← `BRANCH_SHADOW` when a valid jump is written into the ID/EX register.
  - Counter decrements only when it is nonzero and not stalled; invalid cycles also decrement it.
- `stall_out` = `stall_in` | `hazard`.
- Counter width is $clog2(`BRANCH_SHADOW`+1), minimum 1. It saturates at 0.
- Reset mid-stall or mid-shadow returns to the reset state immediately.

Test Plan:
- SUM (type 10, `func` 00000, valid) → next edge: `ALUOp`=000, `RegWrite`=1, `RegSrc2`=1, `RegDtn`=01, `ex_valid`=1.
- CRG `rd`=5, then SUMI `rs1`=5 → `stall_out`=1 for exactly 1 cycle, one bubble, then SUMI issues with `ALUOp`=000, `ALUSrc`=1.
- SI with `BRANCH_SHADOW`=2, then 3 SUM instructions → first 2 SUM squashed (`ex_valid`=0, `shadow_busy`=1), third issues.
- Type 11 or `func` 10101 with type 10 → `illegal`=1 for one cycle, `ex_valid`=0, all controls 0.
- `stall_in`=1 for 3 cycles during the shadow → counter and outputs frozen. `flush_in` with `stall_in` → bubble, `shadow_busy`=0.
- Assert `rst` asynchronously mid-hazard → all outputs 0 before the next clock edge, `stall_out`=0.
